// File: rtl/cdc_tx_queue.sv
//==============================================================================
// Module      : cdc_tx_queue
// Description : Source-side word queue that issues single-cycle pulses to a
//               clock-crossing buffer, with a mandatory gap after every pulse.
//               Optional macro CDC_TX_QUEUE_LEVEL_EN adds the 'level' port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cdc_tx_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     in_clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [WIDTH-1:0]         xb_data,
    output logic                     xb_valid,
    input  logic                     xb_ready,
    output logic                     empty
`ifdef CDC_TX_QUEUE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              push;
    logic              pop;

    // Fullness is judged on the pre-edge count, so a pop never frees a slot
    // for a push on the same edge.
    assign full     = (count == CNT_FULL);
    assign wr_ready = ~full;
    assign empty    = (count == '0);
    assign push     = wr_valid & ~full;

`ifdef CDC_TX_QUEUE_LEVEL_EN
    assign level = count;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && xb_ready) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND:    state_nxt = GAP;
            // xb_ready is ignored here: the far side lowers it one cycle late.
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            xb_valid <= 1'b0;
            xb_data  <= '0;
        end else begin
            state    <= state_nxt;
            xb_valid <= (state_nxt == SEND);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                xb_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cdc_tx_queue.sv
//==============================================================================
// Module      : tb_cdc_tx_queue
// Description : Self-checking bench for cdc_tx_queue (queue model + directed).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cdc_tx_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             in_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [WIDTH-1:0] xb_data;
    logic             xb_valid;
    logic             xb_ready = 1'b0;
    logic             empty;
`ifdef CDC_TX_QUEUE_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    cdc_tx_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .in_clk   (in_clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .xb_data  (xb_data),
        .xb_valid (xb_valid),
        .xb_ready (xb_ready),
        .empty    (empty)
`ifdef CDC_TX_QUEUE_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain word queue plus a rate limiter that forbids a new issue
    // for two cycles after each issue.
    logic [WIDTH-1:0] mq[$];
    int               hold_off;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;

    always @(posedge in_clk or negedge rst_n) begin
        bit acc;
        bit iss;
        if (!rst_n) begin
            mq.delete();
            hold_off  = 0;
            exp_valid = 1'b0;
            exp_data  = '0;
        end else begin
            acc       = wr_valid && (mq.size() < DEPTH);
            iss       = (hold_off == 0) && (mq.size() > 0) && xb_ready;
            exp_valid = iss;
            if (iss) begin
                exp_data = mq.pop_front();
                hold_off = 2;
            end else if (hold_off > 0) begin
                hold_off--;
            end
            if (acc) mq.push_back(wr_data);
        end
    end

    always @(negedge in_clk) begin
        chk("xb_valid", {63'd0, xb_valid}, {63'd0, exp_valid});
        chk("xb_data", {32'd0, xb_data}, {32'd0, exp_data});
        chk("wr_ready", {63'd0, wr_ready}, {63'd0, (mq.size() < DEPTH)});
        chk("empty", {63'd0, empty}, {63'd0, (mq.size() == 0)});
`ifdef CDC_TX_QUEUE_LEVEL_EN
        chk("level", 64'(level), 64'(mq.size()));
`endif
    end

    task automatic tick();
        @(posedge in_clk);
        #2;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] got[$];
        logic [WIDTH-1:0] far[$];
        int               pulse_cyc[$];
        int               idx;
        int               hold;
        int               npulse;
        bit               pend;

        // Reset
        tick();
        tick();
        chk("rst_xb_valid", {63'd0, xb_valid}, 64'd0);
        chk("rst_xb_data", {32'd0, xb_data}, 64'd0);
        chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        rst_n = 1'b1;
        xb_ready = 1'b1;
        tick();

        // Single word and latency
        push(32'habcd6789);
        chk("lat_pre_valid", {63'd0, xb_valid}, 64'd0);
        tick();
        chk("single_valid", {63'd0, xb_valid}, 64'd1);
        chk("single_data", {32'd0, xb_data}, 64'habcd6789);
        chk("single_empty", {63'd0, empty}, 64'd1);
        tick();
        chk("single_pulse_width", {63'd0, xb_valid}, 64'd0);
        repeat (3) tick();

        // Fill with crossing buffer busy
        xb_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push(WIDTH'(i));
        end
        chk("fill_wr_ready", {63'd0, wr_ready}, 64'd0);
`ifdef CDC_TX_QUEUE_LEVEL_EN
        chk("fill_level", 64'(level), 64'd4);
`endif

        // Drain order and spacing
        xb_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (xb_valid) begin
                got.push_back(xb_data);
                pulse_cyc.push_back(c);
            end
        end
        chk("drain_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size(); i++) begin
            chk("drain_word", {32'd0, got[i]}, 64'(i + 1));
        end
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            chk("drain_spacing_ge3", 64'(pulse_cyc[i] - pulse_cyc[i-1] >= 3), 64'd1);
        end

        // Simultaneous push and pop at count 2
        xb_ready = 1'b0;
        push(32'h10);
        push(32'h11);
        xb_ready = 1'b1;
        push(32'h12);
        xb_ready = 1'b0;
        chk("simul_pop_valid", {63'd0, xb_valid}, 64'd1);
        chk("simul_pop_data", {32'd0, xb_data}, 64'h10);
`ifdef CDC_TX_QUEUE_LEVEL_EN
        chk("simul_level", 64'(level), 64'd2);
`endif
        got.delete();
        xb_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (xb_valid) got.push_back(xb_data);
        end
        chk("simul_drain_count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            chk("simul_order0", {32'd0, got[0]}, 64'h11);
            chk("simul_order1", {32'd0, got[1]}, 64'h12);
        end

        // Far-side handshake: xb_ready falls one cycle after each pulse
        idx  = 0;
        hold = 0;
        pend = 1'b0;
        xb_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            bit acc;
            wr_valid = (idx < 8);
            wr_data  = 32'h100 + WIDTH'(idx);
            acc      = wr_valid && wr_ready;
            tick();
            if (acc) idx++;
            if (pend) begin
                xb_ready = 1'b0;
                hold = 3;
                pend = 1'b0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) xb_ready = 1'b1;
            end
            if (xb_valid) begin
                far.push_back(xb_data);
                pend = 1'b1;
            end
        end
        wr_valid = 1'b0;
        chk("far_count", 64'(far.size()), 64'd8);
        for (int i = 0; i < far.size(); i++) begin
            chk("far_word", {32'd0, far[i]}, 64'h100 + 64'(i));
        end

        // Reset during SEND with three words queued
        xb_ready = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            push(32'h200 + WIDTH'(i));
        end
        xb_ready = 1'b1;
        tick();
        chk("pre_rst_valid", {63'd0, xb_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, xb_valid}, 64'd0);
        chk("midrst_empty", {63'd0, empty}, 64'd1);
        chk("midrst_wr_ready", {63'd0, wr_ready}, 64'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        npulse = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (xb_valid) npulse++;
        end
        chk("post_rst_pulses", 64'(npulse), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
